// File: rtl/spi_sensor_poller.sv
// spi_sensor_poller
//
// SPI master for a register-mapped sensor. After reset it sends one 16-bit
// configuration write. It then polls Channels registers of Channel_Bytes
// bytes each, starting at Base_Address. A complete snapshot of all channels
// is published on Data, together with a one-cycle Valid strobe.
//
// Optional feature: define SPI_POLLER_BURST_EN to read a whole frame as one
// multi-byte burst transaction instead of one transaction per channel.
//
// Ports:
//   Clk     in   system clock, rising edge
//   nReset  in   asynchronous active-low reset
//   Enable  in   polling runs while high
//   Data    out  channel snapshot, channel i at [(i+1)*W-1 : i*W]
//   Valid   out  one-Clk pulse when Data updates
//   Busy    out  nCS low or a frame in progress
//   nCS     out  SPI chip select, active low
//   SClk    out  SPI clock, idles at CPOL
//   SDI     out  SPI data to the sensor
//   SDO     in   SPI data from the sensor
module spi_sensor_poller #(
  parameter int          Clock_Div     = 5,
  parameter int          Channels      = 3,
  parameter int          Channel_Bytes = 2,
  parameter bit          CPOL          = 1'b1,
  parameter bit          CPHA          = 1'b1,
  parameter logic [15:0] Init_Word     = 16'h3109,
  parameter logic [5:0]  Base_Address  = 6'h32
) (
  input  logic                                Clk,
  input  logic                                nReset,
  input  logic                                Enable,
  output logic [Channels*Channel_Bytes*8-1:0] Data,
  output logic                                Valid,
  output logic                                Busy,
  output logic                                nCS,
  output logic                                SClk,
  output logic                                SDI,
  input  logic                                SDO
);

  localparam int Total_Bytes = Channels * Channel_Bytes;
  localparam int Ptr_W       = (Total_Bytes > 1) ? $clog2(Total_Bytes) : 1;

`ifdef SPI_POLLER_BURST_EN
  localparam bit Burst = 1'b1;
`else
  localparam bit Burst = 1'b0;
`endif

  // Bits per read transaction: one header byte plus the data bytes.
  localparam int   Frame_Bits = Burst ? (8 + 8 * Total_Bytes) : (8 + 8 * Channel_Bytes);
  localparam logic Multi_Byte = Burst ? 1'b1 : (Channel_Bytes > 1);

  typedef enum logic [2:0] {
    S_INIT,
    S_WAIT_EN,
    S_LOAD,
    S_XFER,
    S_GAP,
    S_PUBLISH
  } state_t;

  state_t state, next_state;

  logic [3:0]                   tick_cnt;
  logic                         tick;
  logic [15:0]                  tx_shift;
  logic [6:0]                   rx_bits;
  logic [9:0]                   xfer_cnt;
  logic [9:0]                   xfer_end;
  logic [9:0]                   bit_cnt;
  logic [Ptr_W-1:0]             byte_ptr;
  logic [3:0]                   ch;
  logic                         init_xfer;
  logic                         in_frame;
  logic [Total_Bytes-1:0][7:0]  shadow;
  logic [5:0]                   ch_addr;
  logic                         last_channel;

  assign tick         = (tick_cnt == 4'(Clock_Div - 1));
  assign ch_addr      = Burst ? Base_Address : (Base_Address + 6'(ch * Channel_Bytes));
  assign last_channel = Burst || (ch == 4'(Channels - 1));
  assign Busy         = !nCS || in_frame;

  // Free-running tick divider; every SPI action waits for a tick.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      tick_cnt <= 4'd0;
    end else if (tick) begin
      tick_cnt <= 4'd0;
    end else begin
      tick_cnt <= tick_cnt + 4'd1;
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state <= S_INIT;
    end else begin
      state <= next_state;
    end
  end

  // States only advance on ticks. The configuration write goes through
  // Xfer/Gap like a read, but then parks in WaitEn so it runs only once.
  always_comb begin
    next_state = state;
    if (tick) begin
      case (state)
        S_INIT:    next_state = S_XFER;
        S_WAIT_EN: if (Enable) next_state = S_LOAD;
        S_LOAD:    next_state = S_XFER;
        S_XFER:    if (xfer_cnt == xfer_end) next_state = S_GAP;
        S_GAP: begin
          if (init_xfer) begin
            next_state = S_WAIT_EN;
          end else if (last_channel) begin
            next_state = S_PUBLISH;
          end else begin
            next_state = S_LOAD;
          end
        end
        S_PUBLISH: next_state = S_WAIT_EN;
        default:   next_state = S_INIT;
      endcase
    end
  end

  // Transaction datapath. Xfer step 0 drops nCS. Steps 1..2B are SClk
  // edges, where odd steps are leading edges. The final step raises nCS.
  // Drive happens where the step parity equals CPHA, and sampling happens
  // on the other edge. Received bytes are stored in arrival order, so the
  // first byte of each channel lands in its least significant byte.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      nCS       <= 1'b1;
      SClk      <= CPOL;
      SDI       <= 1'b1;
      Data      <= '0;
      Valid     <= 1'b0;
      tx_shift  <= '0;
      rx_bits   <= '0;
      xfer_cnt  <= '0;
      xfer_end  <= '0;
      bit_cnt   <= '0;
      byte_ptr  <= '0;
      ch        <= '0;
      init_xfer <= 1'b0;
      in_frame  <= 1'b0;
      shadow    <= '0;
    end else begin
      Valid <= 1'b0;
      if (tick) begin
        case (state)
          S_INIT: begin
            tx_shift  <= Init_Word;
            xfer_end  <= 10'd33;
            xfer_cnt  <= '0;
            bit_cnt   <= '0;
            init_xfer <= 1'b1;
          end
          S_WAIT_EN: begin
            if (Enable) begin
              in_frame <= 1'b1;
              ch       <= '0;
              byte_ptr <= '0;
            end
          end
          S_LOAD: begin
            tx_shift  <= {1'b1, Multi_Byte, ch_addr, 8'h00};
            xfer_end  <= 10'(2 * Frame_Bits + 1);
            xfer_cnt  <= '0;
            bit_cnt   <= '0;
            init_xfer <= 1'b0;
          end
          S_XFER: begin
            xfer_cnt <= xfer_cnt + 10'd1;
            if (xfer_cnt == 10'd0) begin
              nCS <= 1'b0;
              if (!CPHA) begin
                SDI      <= tx_shift[15];
                tx_shift <= {tx_shift[14:0], 1'b0};
              end
            end else if (xfer_cnt == xfer_end) begin
              nCS <= 1'b1;
              SDI <= 1'b1;
            end else begin
              SClk <= ~SClk;
              if (xfer_cnt[0] == CPHA) begin
                SDI      <= tx_shift[15];
                tx_shift <= {tx_shift[14:0], 1'b0};
              end else begin
                rx_bits <= {rx_bits[5:0], SDO};
                bit_cnt <= bit_cnt + 10'd1;
                // The header byte and the whole configuration write are discarded.
                if (!init_xfer && bit_cnt >= 10'd8 && bit_cnt[2:0] == 3'd7) begin
                  shadow[byte_ptr] <= {rx_bits, SDO};
                  byte_ptr         <= byte_ptr + 1'b1;
                end
              end
            end
          end
          S_GAP: begin
            if (!init_xfer && !last_channel) begin
              ch <= ch + 4'd1;
            end
          end
          S_PUBLISH: begin
            Data     <= shadow;
            Valid    <= 1'b1;
            in_frame <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_sensor_poller.sv
// Testbench for spi_sensor_poller. Instance 0 uses the default mode
// (CPOL=1, CPHA=1). Instance 1 uses CPOL=0, CPHA=0. Each instance talks to
// a behavioural sensor that captures SDI and answers reads from a small
// register map.
module tb_spi_sensor_poller;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic en0   = 1'b0;
  logic en1   = 1'b0;
  int   cyc   = 0;
  int   checks = 0;
  int   errors = 0;

`ifdef SPI_POLLER_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif
  localparam logic [47:0] EXP_DATA = 48'h9ABC_5678_1234;
  localparam int          EXP_BITS = BURST ? 56 : 24;
  localparam int          EXP_HDRS = BURST ? 1 : 3;
  localparam logic [7:0]  DROP_HDR = BURST ? 8'hF2 : 8'hF4;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [7:0] reg_byte(input logic [5:0] a);
    case (a)
      6'h32:   return 8'h34;
      6'h33:   return 8'h12;
      6'h34:   return 8'h78;
      6'h35:   return 8'h56;
      6'h36:   return 8'hBC;
      6'h37:   return 8'h9A;
      default: return 8'h00;
    endcase
  endfunction

  // Bit k of the sensor reply: a junk byte during the header, then
  // auto-incrementing register contents.
  function automatic logic resp_bit(input int k, input logic [7:0] h);
    logic [7:0] b;
    if (k < 8) b = 8'hA5;
    else b = reg_byte(h[5:0] + 6'((k / 8) - 1));
    return b[7 - (k % 8)];
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam bit P_CPOL = (g == 0);
    localparam bit P_CPHA = (g == 0);

    logic [47:0] data;
    logic valid, busy, ncs, sclk, sdi;
    logic sdo = 1'b1;
    logic en_i;
    assign en_i = (g == 0) ? en0 : en1;

    spi_sensor_poller #(.CPOL(P_CPOL), .CPHA(P_CPHA)) dut (
      .Clk(clk), .nReset(rst_n), .Enable(en_i), .Data(data), .Valid(valid),
      .Busy(busy), .nCS(ncs), .SClk(sclk), .SDI(sdi), .SDO(sdo)
    );

    int smp = 0, drv = 0, xfers_done = 0, last_bits = 0, hdr_cnt = 0;
    logic [15:0] mosi = '0, last_word = '0;
    logic [7:0]  hdr = '0;
    logic [7:0]  hdr_log [16];
    logic prev_ncs = 1'b1, prev_sclk = P_CPOL;

    always @(ncs or sclk) begin
      if (prev_ncs === 1'b1 && ncs === 1'b0) begin
        smp = 0; drv = 0; mosi = '0;
        if (!P_CPHA) begin sdo = resp_bit(drv, hdr); drv++; end
      end else if (prev_ncs === 1'b0 && ncs === 1'b1) begin
        xfers_done++; last_bits = smp; last_word = mosi;
      end else if (ncs === 1'b0 && sclk !== prev_sclk) begin
        if ((sclk != P_CPOL) == !P_CPHA) begin
          mosi = {mosi[14:0], sdi}; smp++;
          if (smp == 8) begin
            hdr = mosi[7:0]; hdr_log[hdr_cnt % 16] = hdr; hdr_cnt++;
          end
        end else begin
          sdo = resp_bit(drv, hdr); drv++;
        end
      end
      prev_ncs = ncs; prev_sclk = sclk;
    end

    int valid_cnt = 0, sclk_rise = 0, last_rise = 0, period = 0;
    always @(posedge clk) if (valid === 1'b1) valid_cnt++;
    always @(posedge sclk) begin
      sclk_rise++; period = cyc - last_rise; last_rise = cyc;
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; en0 = 1'b0; en1 = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (g_inst[0].ncs !== 1'b1) begin errors++; $display("[TB] FAIL reset_ncs got %b want 1", g_inst[0].ncs); end
    checks++; if (g_inst[0].sclk !== 1'b1) begin errors++; $display("[TB] FAIL reset_sclk0 got %b want 1", g_inst[0].sclk); end
    checks++; if (g_inst[1].sclk !== 1'b0) begin errors++; $display("[TB] FAIL reset_sclk1 got %b want 0", g_inst[1].sclk); end
    checks++; if (g_inst[0].sdi !== 1'b1) begin errors++; $display("[TB] FAIL reset_sdi got %b want 1", g_inst[0].sdi); end
    checks++; if (g_inst[0].data !== 48'h0) begin errors++; $display("[TB] FAIL reset_data got %h want 0", g_inst[0].data); end
    checks++; if (g_inst[0].valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", g_inst[0].valid); end
    checks++; if (g_inst[0].busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", g_inst[0].busy); end
  endtask

  task automatic test_init();
    int b0, b1, r0, v0;
    bit done;
    b0 = g_inst[0].xfers_done; b1 = g_inst[1].xfers_done;
    r0 = g_inst[0].sclk_rise;  v0 = g_inst[0].valid_cnt;
    @(negedge clk) rst_n = 1'b1;
    done = 0;
    for (int i = 0; i < 600 && !done; i++) begin
      @(negedge clk);
      if (g_inst[0].xfers_done > b0 && g_inst[1].xfers_done > b1) done = 1;
    end
    checks++; if (!done) begin errors++; $display("[TB] FAIL init_timeout got no init transaction want one"); end
    checks++; if (g_inst[0].last_word !== 16'h3109) begin errors++; $display("[TB] FAIL init_word0 got %h want 3109", g_inst[0].last_word); end
    checks++; if (g_inst[1].last_word !== 16'h3109) begin errors++; $display("[TB] FAIL init_word1 got %h want 3109", g_inst[1].last_word); end
    checks++; if (g_inst[0].last_bits != 16) begin errors++; $display("[TB] FAIL init_bits got %0d want 16", g_inst[0].last_bits); end
    checks++; if (g_inst[0].sclk_rise - r0 != 16) begin errors++; $display("[TB] FAIL init_sclk_cycles got %0d want 16", g_inst[0].sclk_rise - r0); end
    checks++; if (g_inst[0].period != 10) begin errors++; $display("[TB] FAIL sclk_period0 got %0d want 10", g_inst[0].period); end
    checks++; if (g_inst[1].period != 10) begin errors++; $display("[TB] FAIL sclk_period1 got %0d want 10", g_inst[1].period); end
    repeat (300) @(negedge clk);
    checks++; if (g_inst[0].xfers_done != b0 + 1) begin errors++; $display("[TB] FAIL init_once got %0d want %0d", g_inst[0].xfers_done, b0 + 1); end
    checks++; if (g_inst[0].valid_cnt != v0) begin errors++; $display("[TB] FAIL init_no_valid got %0d want %0d", g_inst[0].valid_cnt, v0); end
    checks++; if (g_inst[0].busy !== 1'b0 || g_inst[0].ncs !== 1'b1) begin errors++; $display("[TB] FAIL init_idle got busy=%b ncs=%b want 0 1", g_inst[0].busy, g_inst[0].ncs); end
    checks++; if (g_inst[0].sclk !== 1'b1 || g_inst[1].sclk !== 1'b0) begin errors++; $display("[TB] FAIL sclk_idle got %b %b want 1 0", g_inst[0].sclk, g_inst[1].sclk); end
  endtask

  task automatic test_poll();
    int vc, hc;
    bit got, early;
    logic [7:0] h;
    logic [7:0] exp_h;
    vc = g_inst[0].valid_cnt; hc = g_inst[0].hdr_cnt;
    got = 0; early = 0;
    en0 = 1'b1;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      if (g_inst[0].valid === 1'b1) got = 1;
      else if (g_inst[0].data !== 48'h0) early = 1;
    end
    checks++; if (!got) begin errors++; $display("[TB] FAIL poll_timeout got no Valid want one"); end
    checks++; if (g_inst[0].data !== EXP_DATA) begin errors++; $display("[TB] FAIL poll_data got %h want %h", g_inst[0].data, EXP_DATA); end
    checks++; if (early) begin errors++; $display("[TB] FAIL poll_partial got early Data change want none"); end
    checks++; if (g_inst[0].hdr_cnt - hc != EXP_HDRS) begin errors++; $display("[TB] FAIL poll_hdr_count got %0d want %0d", g_inst[0].hdr_cnt - hc, EXP_HDRS); end
    for (int j = 0; j < EXP_HDRS; j++) begin
      h = g_inst[0].hdr_log[(hc + j) % 16];
      exp_h = 8'hF2 + 8'(2 * j);
      checks++; if (h !== exp_h) begin errors++; $display("[TB] FAIL poll_header%0d got %h want %h", j, h, exp_h); end
    end
    checks++; if (g_inst[0].last_bits != EXP_BITS) begin errors++; $display("[TB] FAIL poll_bits got %0d want %0d", g_inst[0].last_bits, EXP_BITS); end
    @(negedge clk);
    checks++; if (g_inst[0].valid !== 1'b0) begin errors++; $display("[TB] FAIL valid_width got %b want 0", g_inst[0].valid); end
    checks++; if (g_inst[0].valid_cnt - vc != 1) begin errors++; $display("[TB] FAIL valid_count got %0d want 1", g_inst[0].valid_cnt - vc); end
  endtask

  task automatic test_mode0();
    int hc;
    bit got;
    hc = g_inst[1].hdr_cnt; got = 0;
    en1 = 1'b1;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      if (g_inst[1].valid === 1'b1) got = 1;
    end
    en1 = 1'b0;
    checks++; if (!got) begin errors++; $display("[TB] FAIL mode0_timeout got no Valid want one"); end
    checks++; if (g_inst[1].data !== EXP_DATA) begin errors++; $display("[TB] FAIL mode0_data got %h want %h", g_inst[1].data, EXP_DATA); end
    checks++; if (g_inst[1].hdr_log[hc % 16] !== 8'hF2) begin errors++; $display("[TB] FAIL mode0_header got %h want f2", g_inst[1].hdr_log[hc % 16]); end
    checks++; if (g_inst[1].sclk !== 1'b0) begin errors++; $display("[TB] FAIL mode0_idle got %b want 0", g_inst[1].sclk); end
  endtask

  task automatic test_enable_drop();
    int vc, xd;
    bit found, got;
    found = 0; got = 0;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(negedge clk);
      if (g_inst[0].ncs === 1'b0 && g_inst[0].smp >= 12 && g_inst[0].hdr === DROP_HDR) found = 1;
    end
    checks++; if (!found) begin errors++; $display("[TB] FAIL drop_find got no channel transfer want one"); end
    en0 = 1'b0;
    vc = g_inst[0].valid_cnt;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk);
      if (g_inst[0].valid === 1'b1) got = 1;
    end
    checks++; if (!got) begin errors++; $display("[TB] FAIL drop_timeout got no Valid want one"); end
    checks++; if (g_inst[0].data !== EXP_DATA) begin errors++; $display("[TB] FAIL drop_data got %h want %h", g_inst[0].data, EXP_DATA); end
    xd = g_inst[0].xfers_done;
    repeat (400) @(negedge clk);
    checks++; if (g_inst[0].valid_cnt - vc != 1) begin errors++; $display("[TB] FAIL drop_valid_count got %0d want 1", g_inst[0].valid_cnt - vc); end
    checks++; if (g_inst[0].xfers_done != xd) begin errors++; $display("[TB] FAIL drop_quiet got %0d transfers want 0", g_inst[0].xfers_done - xd); end
    checks++; if (g_inst[0].busy !== 1'b0 || g_inst[0].ncs !== 1'b1) begin errors++; $display("[TB] FAIL drop_idle got busy=%b ncs=%b want 0 1", g_inst[0].busy, g_inst[0].ncs); end
  endtask

  task automatic test_reset_mid();
    int base;
    bit found, done;
    found = 0; done = 0;
    en0 = 1'b1;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(negedge clk);
      if (g_inst[0].ncs === 1'b0 && g_inst[0].smp >= 10) found = 1;
    end
    checks++; if (!found) begin errors++; $display("[TB] FAIL rmid_find got no transfer want one"); end
    rst_n = 1'b0;
    en0 = 1'b0;
    #1;
    checks++; if (g_inst[0].ncs !== 1'b1) begin errors++; $display("[TB] FAIL rmid_ncs got %b want 1", g_inst[0].ncs); end
    checks++; if (g_inst[0].sclk !== 1'b1) begin errors++; $display("[TB] FAIL rmid_sclk got %b want 1", g_inst[0].sclk); end
    checks++; if (g_inst[0].data !== 48'h0) begin errors++; $display("[TB] FAIL rmid_data got %h want 0", g_inst[0].data); end
    checks++; if (g_inst[0].valid !== 1'b0) begin errors++; $display("[TB] FAIL rmid_valid got %b want 0", g_inst[0].valid); end
    repeat (3) @(negedge clk);
    base = g_inst[0].xfers_done;
    rst_n = 1'b1;
    for (int i = 0; i < 600 && !done; i++) begin
      @(negedge clk);
      if (g_inst[0].xfers_done > base) done = 1;
    end
    checks++; if (!done) begin errors++; $display("[TB] FAIL rmid_init_timeout got no init want one"); end
    checks++; if (g_inst[0].last_word !== 16'h3109 || g_inst[0].last_bits != 16) begin
      errors++; $display("[TB] FAIL rmid_init_word got %h/%0d want 3109/16", g_inst[0].last_word, g_inst[0].last_bits);
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_poll();
    test_mode0();
    test_enable_drop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
